m68k_sdram_bridge: RTL and testbench

//  Upstream feeder of the sdram block: converts asynchronous 68000 bus cycles into single-word

---
 rtl/m68k_bus_pkg.sv | 30 +++
 rtl/bit_sync.sv | 24 ++
 rtl/m68k_sdram_bridge.sv | 142 ++++++++++++++
 tb/tb_m68k_sdram_bridge.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared types and helpers for the 68000-to-SDRAM bus bridge.
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RMW_RD,
        RMW_WR,
        ACK,
        BERR
    } bridge_state_t;

    localparam int TMO_W = 8;

    // Replace only the byte lanes whose (active-low) strobe was asserted.
    function automatic logic [15:0] merge_lane(
        input logic [15:0] old_word,
        input logic [15:0] new_word,
        input logic        uds_n,
        input logic        lds_n
    );
        logic [15:0] merged;
        merged = old_word;
        if (!uds_n) merged[15:8] = new_word[15:8];
        if (!lds_n) merged[7:0]  = new_word[7:0];
        return merged;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for one asynchronous strobe; resets to the negated (high) level.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: non-blocking assignments make each stage capture its neighbour's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/m68k_sdram_bridge.sv
// Turns asynchronous 68000 bus cycles into single-word SDRAM requests, with
// read-modify-write for byte writes, DTACK/BERR generation and a request timeout.
module m68k_sdram_bridge
    import m68k_bus_pkg::*;
#(
    parameter logic [25:0] SDRAM_BASE  = 26'h0,
    parameter int          SYNC_STAGES = 2,
    parameter int          TIMEOUT     = 255
) (
    input  logic        ext_clk,
    input  logic        rst,
    input  logic        cpu_sel,
    input  logic        cpu_as_n,
    input  logic        cpu_uds_n,
    input  logic        cpu_lds_n,
    input  logic        cpu_rw,
    input  logic [22:0] cpu_addr,
    input  logic [15:0] cpu_data_in,
    output logic [15:0] cpu_data_out,
    output logic        cpu_data_oe,
    output logic        cpu_dtack_n,
    output logic        cpu_berr_n,
    output logic        mem_enable,
    output logic        mem_write,
    output logic [25:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready
);

    logic as_s;
    logic uds_s;
    logic lds_s;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_as  (.clk(ext_clk), .rst(rst), .d_i(cpu_as_n),  .q_o(as_s));
    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_uds (.clk(ext_clk), .rst(rst), .d_i(cpu_uds_n), .q_o(uds_s));
    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_lds (.clk(ext_clk), .rst(rst), .d_i(cpu_lds_n), .q_o(lds_s));

    bridge_state_t    state_q;
    logic             uds_n_q;
    logic             lds_n_q;
    logic [15:0]      data_q;
    logic [TMO_W-1:0] tmo_q;

    logic start;
    logic mem_done;
    logic timed_out;

    assign start     = !as_s && (!uds_s || !lds_s) && cpu_sel;
    assign mem_done  = mem_enable && mem_ready;
    assign timed_out = (tmo_q == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge ext_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            uds_n_q      <= 1'b1;
            lds_n_q      <= 1'b1;
            data_q       <= '0;
            tmo_q        <= '0;
            cpu_data_out <= '0;
            cpu_data_oe  <= 1'b0;
            cpu_dtack_n  <= 1'b1;
            cpu_berr_n   <= 1'b1;
            mem_enable   <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        uds_n_q    <= uds_s;
                        lds_n_q    <= lds_s;
                        data_q     <= cpu_data_in;
                        tmo_q      <= '0;
                        mem_enable <= 1'b1;
                        mem_addr   <= SDRAM_BASE + {3'b000, cpu_addr};
                        if (cpu_rw) begin
                            mem_write <= 1'b0;
                            state_q   <= RD;
                        end else if (!uds_s && !lds_s) begin
                            mem_write <= 1'b1;
                            mem_wdata <= cpu_data_in;
                            state_q   <= WR;
                        end else begin
                            mem_write <= 1'b0;
                            state_q   <= RMW_RD;
                        end
                    end
                end

                RD, WR, RMW_RD, RMW_WR: begin
                    if (mem_done) begin
                        mem_enable <= 1'b0;
                        // A CPU that has dropped AS is gone: finish the access silently.
                        if (as_s) begin
                            state_q <= IDLE;
                        end else if (state_q == RD) begin
                            cpu_data_out <= mem_rdata;
                            cpu_data_oe  <= 1'b1;
                            cpu_dtack_n  <= 1'b0;
                            state_q      <= ACK;
                        end else if (state_q == RMW_RD) begin
                            mem_write <= 1'b1;
                            mem_wdata <= merge_lane(mem_rdata, data_q, uds_n_q, lds_n_q);
                            state_q   <= RMW_WR;
                        end else begin
                            cpu_dtack_n <= 1'b0;
                            state_q     <= ACK;
                        end
                    end else if (timed_out) begin
                        mem_enable <= 1'b0;
                        cpu_berr_n <= as_s;
                        state_q    <= as_s ? IDLE : BERR;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                        // Re-raises the request after the idle gap that separates RMW read and write.
                        mem_enable <= 1'b1;
                    end
                end

                ACK: begin
                    if (as_s) begin
                        cpu_dtack_n <= 1'b1;
                        cpu_data_oe <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                BERR: begin
                    if (as_s) begin
                        cpu_berr_n <= 1'b1;
                        state_q    <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_sdram_bridge.sv
// Randomised bench for m68k_sdram_bridge: an SDRAM responder plus a per-bus-cycle reference model.
module tb_m68k_sdram_bridge;

    localparam logic [25:0] WRAP_BASE = 26'h3FFFFFF;

    typedef struct packed {
        logic        wr;
        logic [25:0] addr;
        logic [15:0] wdata;
    } req_t;

    logic        ext_clk     = 1'b0;
    logic        rst         = 1'b0;
    logic        cpu_sel     = 1'b0;
    logic        cpu_as_n    = 1'b1;
    logic        cpu_uds_n   = 1'b1;
    logic        cpu_lds_n   = 1'b1;
    logic        cpu_rw      = 1'b1;
    logic [22:0] cpu_addr    = '0;
    logic [15:0] cpu_data_in = '0;
    logic [15:0] mem_rdata   = '0;
    logic        mem_ready   = 1'b0;

    logic [15:0] cpu_data_out, w_cpu_data_out;
    logic        cpu_data_oe, w_cpu_data_oe;
    logic        cpu_dtack_n, w_cpu_dtack_n;
    logic        cpu_berr_n, w_cpu_berr_n;
    logic        mem_enable, w_mem_enable;
    logic        mem_write, w_mem_write;
    logic [25:0] mem_addr, w_mem_addr;
    logic [15:0] mem_wdata, w_mem_wdata;

    m68k_sdram_bridge dut (
        .ext_clk(ext_clk), .rst(rst), .cpu_sel(cpu_sel), .cpu_as_n(cpu_as_n),
        .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .cpu_data_oe(cpu_data_oe),
        .cpu_dtack_n(cpu_dtack_n), .cpu_berr_n(cpu_berr_n), .mem_enable(mem_enable),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // Twin with a base offset that forces address wrap-around; shares all stimulus.
    m68k_sdram_bridge #(.SDRAM_BASE(WRAP_BASE)) dut_wrap (
        .ext_clk(ext_clk), .rst(rst), .cpu_sel(cpu_sel), .cpu_as_n(cpu_as_n),
        .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_data_in(cpu_data_in), .cpu_data_out(w_cpu_data_out), .cpu_data_oe(w_cpu_data_oe),
        .cpu_dtack_n(w_cpu_dtack_n), .cpu_berr_n(w_cpu_berr_n), .mem_enable(w_mem_enable),
        .mem_write(w_mem_write), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 ext_clk = ~ext_clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] sdram [logic [25:0]];
    req_t        req_log[$];
    int          fixed_lat = -1;
    bit          resp_on = 1'b1;
    int          aborts = 0;
    int          last_hi = 0;
    logic [25:0] last_wrap_addr = '0;
    bit          dtack_seen = 1'b0;

    function automatic logic [15:0] sdram_get(input logic [25:0] a);
        if (sdram.exists(a)) return sdram[a];
        return a[15:0] ^ 16'hC35A;
    endfunction

    function automatic req_t mk_req(input logic wr, input logic [25:0] a, input logic [15:0] d);
        req_t r;
        r.wr    = wr;
        r.addr  = a;
        r.wdata = d;
        return r;
    endfunction

    // SDRAM responder: random or fixed latency, optional never-ready, logs completed requests.
    initial begin : responder
        req_t        cur;
        logic [25:0] exp_wrap;
        int          n;
        int          lat;
        forever begin
            @(negedge ext_clk);
            if (mem_enable === 1'b1) begin
                cur = mk_req(mem_write, mem_addr, mem_wdata);
                exp_wrap = mem_addr + WRAP_BASE;
                last_wrap_addr = w_mem_addr;
                check("wrap_addr", w_mem_addr, exp_wrap);
                lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                n = 0;
                while (!(resp_on && n == lat)) begin
                    @(negedge ext_clk);
                    n++;
                    if (mem_enable !== 1'b1) break;
                    check("req_hold", {mem_write, mem_addr, mem_wdata}, cur);
                end
                if (mem_enable === 1'b1) begin
                    if (cur.wr) sdram[cur.addr] = cur.wdata;
                    else mem_rdata = sdram_get(cur.addr);
                    req_log.push_back(cur);
                    mem_ready = 1'b1;
                    @(negedge ext_clk);
                    mem_ready = 1'b0;
                    check("req_gap", mem_enable, 1'b0);
                end else begin
                    aborts++;
                    last_hi = n;
                end
            end
        end
    end

    initial begin : dtack_monitor
        forever begin
            @(negedge ext_clk);
            if (cpu_dtack_n === 1'b0) dtack_seen = 1'b1;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

    task automatic start_bus(input logic rw, input logic [22:0] a, input logic u_n,
                             input logic l_n, input logic [15:0] wd);
        @(negedge ext_clk);
        cpu_addr    = a;
        cpu_rw      = rw;
        cpu_data_in = wd;
        cpu_sel     = 1'b1;
        cpu_as_n    = 1'b0;
        @(negedge ext_clk);
        cpu_uds_n = u_n;
        cpu_lds_n = l_n;
    endtask

    task automatic release_bus();
        int t;
        @(negedge ext_clk);
        cpu_as_n  = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
        cpu_sel   = 1'b0;
        t = 0;
        while ((cpu_dtack_n !== 1'b1 || cpu_berr_n !== 1'b1) && t < 20) begin
            @(negedge ext_clk);
            t++;
        end
    endtask

    // One complete bus cycle checked against the model: expected requests, data, memory, DTACK.
    task automatic bus_cycle(input string tag, input logic rw, input logic [22:0] a,
                             input logic u_n, input logic l_n, input logic [15:0] wd);
        logic [25:0] ea;
        logic [15:0] old;
        logic [15:0] keep;
        logic [15:0] merged;
        req_t        exp_q[$];
        int          t;
        ea     = {3'b000, a};
        old    = sdram_get(ea);
        keep   = (u_n ? 16'hFF00 : 16'h0000) | (l_n ? 16'h00FF : 16'h0000);
        merged = (old & keep) | (wd & ~keep);
        if (rw) begin
            exp_q.push_back(mk_req(1'b0, ea, 16'h0));
        end else if (!u_n && !l_n) begin
            exp_q.push_back(mk_req(1'b1, ea, wd));
        end else begin
            exp_q.push_back(mk_req(1'b0, ea, 16'h0));
            exp_q.push_back(mk_req(1'b1, ea, merged));
        end
        req_log.delete();
        start_bus(rw, a, u_n, l_n, wd);
        t = 0;
        while (cpu_dtack_n === 1'b1 && cpu_berr_n === 1'b1 && t < 2000) begin
            @(negedge ext_clk);
            t++;
        end
        check({tag, "_dtack"}, cpu_dtack_n, 1'b0);
        check({tag, "_berr"}, cpu_berr_n, 1'b1);
        if (rw) begin
            check({tag, "_rdata"}, cpu_data_out, old);
            check({tag, "_oe"}, cpu_data_oe, 1'b1);
        end else begin
            check({tag, "_mem"}, sdram_get(ea), merged);
        end
        check({tag, "_nreq"}, req_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < req_log.size(); i++) begin
            check({tag, "_req_wr"}, req_log[i].wr, exp_q[i].wr);
            check({tag, "_req_addr"}, req_log[i].addr, exp_q[i].addr);
            if (exp_q[i].wr) check({tag, "_req_wdata"}, req_log[i].wdata, exp_q[i].wdata);
        end
        release_bus();
        check({tag, "_dtack_rel"}, cpu_dtack_n, 1'b1);
        check({tag, "_oe_rel"}, cpu_data_oe, 1'b0);
    endtask

    initial begin : main
        int          t;
        int          a0;
        logic [22:0] pool [8];
        logic [22:0] a;
        logic        rw;
        int          s;

        #2 rst = 1'b1;
        #1;
        check("rst_out", {cpu_dtack_n, cpu_berr_n, cpu_data_oe, cpu_data_out, mem_enable,
                          mem_write, mem_addr, mem_wdata},
              {1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 16'h0});
        repeat (3) @(negedge ext_clk);
        rst = 1'b0;
        repeat (3) @(negedge ext_clk);

        fixed_lat = 3;
        sdram[26'h40] = 16'hBEEF;
        bus_cycle("rd_beef", 1'b1, 23'h40, 1'b0, 1'b0, 16'h0);
        fixed_lat = -1;

        bus_cycle("wr_1234", 1'b0, 23'h80, 1'b0, 1'b0, 16'h1234);
        if (req_log.size() > 0) check("wr_1234_addr", req_log[0].addr, 26'h80);

        sdram[26'h200] = 16'h5566;
        bus_cycle("uds_aa", 1'b0, 23'h200, 1'b0, 1'b1, 16'hAA00);
        check("uds_aa_word", sdram_get(26'h200), 16'hAA66);
        sdram[26'h200] = 16'h5566;
        bus_cycle("lds_aa", 1'b0, 23'h200, 1'b1, 1'b0, 16'h00AA);
        check("lds_aa_word", sdram_get(26'h200), 16'h55AA);

        bus_cycle("wrap", 1'b1, 23'h1, 1'b0, 1'b0, 16'h0);
        check("wrap_addr0", last_wrap_addr, 26'h0);

        // Deselected cycle: must be ignored entirely.
        req_log.delete();
        dtack_seen = 1'b0;
        a0 = aborts;
        @(negedge ext_clk);
        cpu_sel   = 1'b0;
        cpu_rw    = 1'b1;
        cpu_as_n  = 1'b0;
        cpu_uds_n = 1'b0;
        cpu_lds_n = 1'b0;
        repeat (20) @(negedge ext_clk);
        check("nosel_req", req_log.size() + aborts - a0, 0);
        check("nosel_dtack", dtack_seen, 1'b0);
        check("nosel_berr", cpu_berr_n, 1'b1);
        release_bus();

        // SDRAM never answers: abort after TIMEOUT cycles, BERR until AS negates.
        resp_on = 1'b0;
        dtack_seen = 1'b0;
        a0 = aborts;
        start_bus(1'b1, 23'h123, 1'b0, 1'b0, 16'h0);
        t = 0;
        while (cpu_berr_n === 1'b1 && t < 600) begin
            @(negedge ext_clk);
            t++;
        end
        check("tmo_berr", cpu_berr_n, 1'b0);
        @(negedge ext_clk);
        check("tmo_abort", aborts, a0 + 1);
        check("tmo_len", last_hi, 255);
        repeat (5) @(negedge ext_clk);
        check("tmo_berr_hold", cpu_berr_n, 1'b0);
        check("tmo_no_dtack", dtack_seen, 1'b0);
        release_bus();
        check("tmo_berr_rel", cpu_berr_n, 1'b1);
        resp_on = 1'b1;

        // AS negated during the RMW read: read completes, write skipped, no DTACK.
        fixed_lat = 15;
        sdram[26'h300] = 16'h1357;
        req_log.delete();
        dtack_seen = 1'b0;
        start_bus(1'b0, 23'h300, 1'b0, 1'b1, 16'hFF00);
        t = 0;
        while (mem_enable !== 1'b1 && t < 20) begin
            @(negedge ext_clk);
            t++;
        end
        check("asab_started", mem_enable, 1'b1);
        release_bus();
        repeat (40) @(negedge ext_clk);
        check("asab_nreq", req_log.size(), 1);
        if (req_log.size() > 0) check("asab_is_read", req_log[0].wr, 1'b0);
        check("asab_mem", sdram_get(26'h300), 16'h1357);
        check("asab_no_dtack", dtack_seen, 1'b0);
        check("asab_berr", cpu_berr_n, 1'b1);

        // Reset while the RMW write is outstanding.
        fixed_lat = 4;
        sdram[26'h310] = 16'h2468;
        start_bus(1'b0, 23'h310, 1'b1, 1'b0, 16'h0011);
        t = 0;
        while (!(mem_enable === 1'b1 && mem_write === 1'b1) && t < 40) begin
            @(negedge ext_clk);
            t++;
        end
        check("rstw_in_write", {mem_enable, mem_write}, 2'b11);
        rst = 1'b1;
        #1;
        check("rstw_out", {cpu_dtack_n, cpu_berr_n, cpu_data_oe, cpu_data_out, mem_enable,
                           mem_write, mem_addr, mem_wdata},
              {1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 16'h0});
        cpu_as_n  = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
        cpu_sel   = 1'b0;
        repeat (2) @(negedge ext_clk);
        rst = 1'b0;
        repeat (3) @(negedge ext_clk);
        check("rstw_mem", sdram_get(26'h310), 16'h2468);
        fixed_lat = -1;
        bus_cycle("post_rst", 1'b0, 23'h310, 1'b1, 1'b0, 16'h0099);

        // Random traffic over a small address pool so reads observe earlier writes.
        for (int i = 0; i < 8; i++) pool[i] = 23'($urandom);
        for (int i = 0; i < 40; i++) begin
            a  = ($urandom_range(0, 3) == 0) ? 23'($urandom) : pool[$urandom_range(0, 7)];
            rw = 1'($urandom);
            s  = int'($urandom_range(0, 2));
            bus_cycle("rand", rw, a, s == 2, s == 1, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
